// File: rtl/fcmp_unit.sv
// fcmp_unit: two-stage pipelined single-precision compare/select unit.
//
// Computes feq/flt/fle (0/1 result, zero-extended) and fmin/fmax (selected operand)
// for requests from the FPU dispatcher. One result per cycle at full throughput.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (req_ready is combinational)
//   req_op                000 feq, 001 flt, 010 fle, 011 fmin, 100 fmax, others reserved
//   req_x1, req_x2        IEEE-754 single operands
//   req_tag               destination tag, returned with the result
//   resp_valid/resp_ready response handshake
//   resp_y, resp_tag      result and its tag, held stable while stalled
module fcmp_unit #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_x1,
    input  logic [31:0]      req_x2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_y,
    output logic [TAG_W-1:0] resp_tag
);

    localparam logic [2:0] OpFeq  = 3'd0;
    localparam logic [2:0] OpFlt  = 3'd1;
    localparam logic [2:0] OpFle  = 3'd2;
    localparam logic [2:0] OpFmin = 3'd3;
    localparam logic [2:0] OpFmax = 3'd4;

    localparam logic [31:0] CanonNan = 32'h7fc00000;
    localparam logic [31:0] NegZero  = 32'h80000000;

    // Stage 1 state
    logic             s1_valid_q;
    logic [2:0]       s1_op_q;
    logic [31:0]      s1_x1_q, s1_x2_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic             s1_nan1_q, s1_nan2_q, s1_zero1_q, s1_zero2_q;
    logic             s1_mag_lt_q, s1_mag_eq_q;

    // Stage 2 state
    logic             s2_valid_q;
    logic [31:0]      s2_y_q, s2_y_d;
    logic [TAG_W-1:0] s2_tag_q;

    logic s1_adv, s2_adv;
    logic nan1_d, nan2_d, zero1_d, zero2_d;

    always_comb begin
        s2_adv  = !s2_valid_q || resp_ready;
        s1_adv  = !s1_valid_q || s2_adv;
        nan1_d  = (req_x1[30:23] == 8'hff) && (req_x1[22:0] != 23'd0);
        nan2_d  = (req_x2[30:23] == 8'hff) && (req_x2[22:0] != 23'd0);
        zero1_d = (req_x1[30:0] == 31'd0);
        zero2_d = (req_x2[30:0] == 31'd0);
    end

    assign req_ready  = s1_adv && !rst;
    // Masked during reset so no stale result is visible in the reset cycle.
    assign resp_valid = s2_valid_q && !rst;
    assign resp_y     = s2_y_q;
    assign resp_tag   = s2_tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= req_valid;
            if (req_valid) begin
                s1_op_q     <= req_op;
                s1_x1_q     <= req_x1;
                s1_x2_q     <= req_x2;
                s1_tag_q    <= req_tag;
                s1_nan1_q   <= nan1_d;
                s1_nan2_q   <= nan2_d;
                s1_zero1_q  <= zero1_d;
                s1_zero2_q  <= zero2_d;
                s1_mag_lt_q <= req_x1[30:0] < req_x2[30:0];
                s1_mag_eq_q <= req_x1[30:0] == req_x2[30:0];
            end
        end
    end

    logic sgn1, sgn2, both_zero, any_nan, lt, eq;

    always_comb begin
        sgn1      = s1_x1_q[31];
        sgn2      = s1_x2_q[31];
        both_zero = s1_zero1_q && s1_zero2_q;
        any_nan   = s1_nan1_q || s1_nan2_q;

        // Sign-magnitude ordering; +0 and -0 compare equal.
        if (both_zero) begin
            lt = 1'b0;
        end else if (sgn1 != sgn2) begin
            lt = sgn1;
        end else if (!sgn1) begin
            lt = s1_mag_lt_q;
        end else begin
            lt = !s1_mag_lt_q && !s1_mag_eq_q;
        end
        eq = both_zero || (s1_mag_eq_q && (sgn1 == sgn2));

        s2_y_d = 32'd0;
        unique case (s1_op_q)
            OpFeq: s2_y_d = {31'd0, !any_nan && eq};
            OpFlt: s2_y_d = {31'd0, !any_nan && lt};
            OpFle: s2_y_d = {31'd0, !any_nan && (lt || eq)};
            OpFmin, OpFmax: begin
                if (s1_nan1_q && s1_nan2_q) begin
                    s2_y_d = CanonNan;
                end else if (s1_nan1_q) begin
                    s2_y_d = s1_x2_q;
                end else if (s1_nan2_q) begin
                    s2_y_d = s1_x1_q;
                end else if (both_zero) begin
                    // fmin prefers -0, fmax prefers +0, independent of operand order.
                    if (s1_op_q == OpFmin) begin
                        s2_y_d = (sgn1 || sgn2) ? NegZero : 32'd0;
                    end else begin
                        s2_y_d = (sgn1 && sgn2) ? NegZero : 32'd0;
                    end
                end else if (s1_op_q == OpFmin) begin
                    s2_y_d = (lt || eq) ? s1_x1_q : s1_x2_q;
                end else begin
                    s2_y_d = lt ? s1_x2_q : s1_x1_q;
                end
            end
            default: s2_y_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_y_q     <= 32'd0;
            s2_tag_q   <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_y_q   <= s2_y_d;
                s2_tag_q <= s1_tag_q;
            end
        end
    end

endmodule

// File: tb/tb_fcmp_unit.sv
// Scoreboard bench for fcmp_unit: the driver pushes expected results, a monitor pops
// and compares on every response transfer.
module tb_fcmp_unit;

    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [31:0]   req_x1, req_x2;
    logic [TW-1:0] req_tag;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_y;
    logic [TW-1:0] resp_tag;

    fcmp_unit #(.TAG_W(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_x1     (req_x1),
        .req_x2     (req_x2),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .resp_tag   (resp_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]   y;
        logic [TW-1:0] tag;
        int            acc;
        bit            lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: a transfer happens at the next posedge when valid && ready here.
    always @(negedge clk) begin
        if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=%h/%0d required=none", resp_y, resp_tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_y", resp_y, e.y);
                check("resp_tag", 32'(resp_tag), 32'(e.tag));
                if (e.lat) check("latency", cyc, e.acc + 2);
            end
        end
    end

    // Called at posedge+#1; leaves req_valid high so consecutive calls are back-to-back.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TW-1:0] tag, input logic [31:0] ey, input bit lat);
        bit   done;
        exp_t e;
        done      = 1'b0;
        req_valid = 1'b1;
        req_op    = op;
        req_x1    = a;
        req_x2    = b;
        req_tag   = tag;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                e.y = ey; e.tag = tag; e.acc = cyc; e.lat = lat;
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout actual=req_ready_low required=accept");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    function automatic bit is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hff) && (v[22:0] != 23'd0);
    endfunction

    function automatic real to_real(input logic [31:0] v);
        real r;
        int  e;
        if (v[30:23] == 8'hff) begin
            r = 1.0e300;
        end else begin
            r = (v[30:23] == 8'd0) ? real'(v[22:0]) : real'({1'b1, v[22:0]});
            e = (v[30:23] == 8'd0) ? -149 : int'(v[30:23]) - 150;
            while (e > 0) begin r = r * 2.0; e--; end
            while (e < 0) begin r = r * 0.5; e++; end
        end
        return v[31] ? -r : r;
    endfunction

    function automatic logic [31:0] ref_cmp(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        real ra, rb;
        if (is_nan(a) || is_nan(b)) return 32'd0;
        ra = to_real(a);
        rb = to_real(b);
        case (op)
            3'd0:    return {31'd0, ra == rb};
            3'd1:    return {31'd0, ra < rb};
            default: return {31'd0, ra <= rb};
        endcase
    endfunction

    // Directed vectors: op, x1, x2, hand-computed result.
    localparam int ND = 16;
    logic [2:0]  d_op [ND] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd0, 3'd1, 3'd3, 3'd4,
                               3'd3, 3'd4, 3'd4, 3'd3, 3'd0, 3'd2, 3'd5, 3'd4};
    logic [31:0] d_x1 [ND] = '{32'h3f800000, 32'hbf800000, 32'h80000000, 32'h80000000,
                               32'h80000000, 32'h7fc00000, 32'h7fc00001, 32'h7fc00001,
                               32'h00000000, 32'hc0000000, 32'h80000000, 32'h40000000,
                               32'h3f800000, 32'h40000000, 32'h3f800000, 32'hff800000};
    logic [31:0] d_x2 [ND] = '{32'h40000000, 32'hc0000000, 32'h00000000, 32'h00000000,
                               32'h00000000, 32'h3f800000, 32'h40400000, 32'hffc00000,
                               32'h80000000, 32'hbf800000, 32'h00000000, 32'h3f800000,
                               32'h3f800000, 32'h3f800000, 32'h40000000, 32'h3f800000};
    logic [31:0] d_ey [ND] = '{32'h1, 32'h0, 32'h0, 32'h1,
                               32'h1, 32'h0, 32'h40400000, 32'h7fc00000,
                               32'h80000000, 32'hbf800000, 32'h00000000, 32'h3f800000,
                               32'h1, 32'h0, 32'h0, 32'h3f800000};

    // Backpressure vectors; the third is presented but must not be accepted.
    logic [2:0]  b_op [3] = '{3'd4, 3'd2, 3'd1};
    logic [31:0] b_x1 [3] = '{32'h40400000, 32'hc0400000, 32'h00000000};
    logic [31:0] b_x2 [3] = '{32'h40800000, 32'hc0400000, 32'h3f800000};
    logic [31:0] b_ey [3] = '{32'h40800000, 32'h1, 32'h1};

    initial begin
        logic [31:0] a, b, m, hold_y;
        logic [TW-1:0] hold_tag;
        logic [22:0] mants [5];
        int  n;
        bit  seen;
        exp_t e;

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_x1 = '0; req_x2 = '0;
        req_tag = '0; resp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_y", resp_y, 0);
        check("rst_resp_tag", 32'(resp_tag), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 1);
        @(posedge clk); #1;

        // Directed compare / select vectors, latency checked
        for (int i = 0; i < ND; i++) issue(d_op[i], d_x1[i], d_x2[i], TW'(i), d_ey[i], 1'b1);
        req_valid = 1'b0;
        drain();

        // Throughput: 16 back-to-back fmin with tags 0..15
        for (int i = 0; i < 16; i++) begin
            a = 32'h3f800000 + 32'(i);
            b = 32'h3f800008;
            issue(3'd3, a, b, TW'(i), (i <= 8) ? a : b, 1'b1);
        end
        req_valid = 1'b0;
        drain();

        // Backpressure: resp_ready low for 5 cycles with requests pending
        resp_ready = 1'b0;
        n = 0; seen = 1'b0;
        req_valid = 1'b1; req_op = b_op[0]; req_x1 = b_x1[0]; req_x2 = b_x2[0];
        req_tag = TW'(20);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (req_ready && n < 3) begin
                e.y = b_ey[n]; e.tag = TW'(20 + n); e.acc = cyc; e.lat = 1'b0;
                exp_q.push_back(e);
                n++;
            end
            if (resp_valid) begin
                if (seen) begin
                    check("stall_y_stable", resp_y, hold_y);
                    check("stall_tag_stable", 32'(resp_tag), 32'(hold_tag));
                end
                seen = 1'b1; hold_y = resp_y; hold_tag = resp_tag;
            end
            @(posedge clk); #1;
            if (n < 3) begin
                req_op = b_op[n]; req_x1 = b_x1[n]; req_x2 = b_x2[n]; req_tag = TW'(20 + n);
            end
        end
        @(negedge clk);
        check("stall_accepts", n, 2);
        check("stall_req_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        drain();

        // Reset with both stages full: nothing stale may emerge
        resp_ready = 1'b0;
        issue(3'd1, 32'h3f800000, 32'h40000000, TW'(7), 32'h1, 1'b0);
        issue(3'd4, 32'h3f800000, 32'h40000000, TW'(8), 32'h40000000, 1'b0);
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        check("midrst_req_ready", 32'(req_ready), 0);
        check("midrst_resp_valid", 32'(resp_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        resp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("after_rst_resp_valid", 32'(resp_valid), 0);
            if (c == 0) check("after_rst_req_ready", 32'(req_ready), 1);
            @(posedge clk); #1;
        end

        // Sweep against the real-valued model
        mants[0] = 23'd0; mants[1] = 23'd1; mants[2] = 23'h400000; mants[3] = 23'h7fffff;
        for (int s = 0; s < 2; s++) begin
            for (int ex = 0; ex < 256; ex++) begin
                mants[4] = 23'($urandom);
                for (int k = 0; k < 5; k++) begin
                    a = {s[0], ex[7:0], mants[k]};
                    for (int p = 0; p < 3; p++) begin
                        if (p == 0) begin
                            b = a;
                        end else if (p == 1) begin
                            m = 32'(mants[k]) ^ 32'($urandom_range(1, 255));
                            b = {s[0], ex[7:0], m[22:0]};
                        end else begin
                            m = $urandom;
                            b = {m[31], 8'(ex + 1), m[22:0]};
                        end
                        for (int op = 0; op < 3; op++)
                            issue(3'(op), a, b, TW'(op + 3 * p), ref_cmp(3'(op), a, b), 1'b1);
                    end
                end
            end
        end
        req_valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
